// File: rtl/cam_search_ctrl.sv
// CAM search controller: drives negedge CAM cells, tracks valid bits,
// serves search/write/invalidate/flush over valid/ready handshakes.
module cam_search_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [1:0]             req_op_i,
  input  logic [WIDTH-1:0]       req_key_i,
  input  logic [IDX_W-1:0]       req_index_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic                   rsp_hit_o,
  output logic [IDX_W-1:0]       rsp_index_o,
  output logic                   rsp_multi_o,
  output logic [WIDTH-1:0]       cell_data_o,
  output logic [DEPTH-1:0]       cell_write_enable_o,
  output logic                   cell_compare_enable_o,
  output logic [WIDTH-1:0]       cell_compare_o,
  input  logic [DEPTH*WIDTH-1:0] cell_match_i
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    SEARCH,
    RESP
  } state_t;

  localparam logic [1:0] OP_SRCH = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_INV = 2'b10;
  localparam logic [1:0] OP_FLUSH = 2'b11;
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

  state_t state_q, state_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] word_match;
  logic [DEPTH-1:0] idx_mask;
  logic idx_ok;
  logic accept;
  logic hit_c, multi_c;
  logic [IDX_W-1:0] index_c;

  assign accept = (state_q == IDLE) && req_valid_i;
  assign idx_ok = {1'b0, req_index_i} < DEPTH_L;
  assign idx_mask = idx_ok ? (DEPTH'(1) << req_index_i) : '0;

  for (genvar i = 0; i < DEPTH; i++) begin : g_wm
    assign word_match[i] =
      (&cell_match_i[i*WIDTH +: WIDTH]) & valid_q[i];
  end

  // Priority-encode the lowest matching word and flag duplicates.
  always_comb begin
    hit_c = 1'b0;
    multi_c = 1'b0;
    index_c = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (word_match[i]) index_c = IDX_W'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (word_match[i]) begin
        if (hit_c) multi_c = 1'b1;
        hit_c = 1'b1;
      end
    end
  end

  // Next state and next valid-bit vector.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          unique case (req_op_i)
            OP_SRCH:  state_d = SEARCH;
            OP_WR:    state_d = WRITE;
            OP_INV:   valid_d = valid_q & ~idx_mask;
            OP_FLUSH: valid_d = '0;
            default:  state_d = IDLE;
          endcase
        end
      end
      WRITE: begin
        state_d = IDLE;
        valid_d = valid_q | cell_write_enable_o;
      end
      SEARCH: state_d = RESP;
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and valid-bit registers.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  // Registered handshake, response and cell-drive outputs.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_hit_o <= 1'b0;
      rsp_index_o <= '0;
      rsp_multi_o <= 1'b0;
      cell_data_o <= '0;
      cell_write_enable_o <= '0;
      cell_compare_enable_o <= 1'b0;
      cell_compare_o <= '0;
    end else begin
      req_ready_o <= (state_d == IDLE);
      cell_write_enable_o <= '0;
      cell_compare_enable_o <= 1'b0;
      if (accept && req_op_i == OP_WR) begin
        cell_write_enable_o <= idx_mask;
        cell_data_o <= req_key_i;
      end
      if (accept && req_op_i == OP_SRCH) begin
        cell_compare_enable_o <= 1'b1;
        cell_compare_o <= req_key_i;
      end
      if (state_q == SEARCH) begin
        rsp_valid_o <= 1'b1;
        rsp_hit_o <= hit_c;
        rsp_index_o <= index_c;
        rsp_multi_o <= multi_c;
      end
      if (state_q == RESP && rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cam_search_ctrl.sv
// Directed bench for cam_search_ctrl with behavioural
// negedge CAM cell arrays for an 8-deep and a 6-deep instance.
module tb_cam_search_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid8, req_valid6, rsp_ready;
  logic [1:0] req_op;
  logic [7:0] req_key;
  logic [2:0] req_index;

  logic rdy8, rv8, hit8, mu8, ce8;
  logic [2:0] ix8;
  logic [7:0] data8, we8, cmp8;
  logic [63:0] match8;

  logic rdy6, rv6, hit6, mu6, ce6;
  logic [2:0] ix6;
  logic [7:0] data6, cmp6;
  logic [5:0] we6;
  logic [47:0] match6;

  logic [7:0] mem8 [8];
  logic [7:0] mat8 [8];
  logic [7:0] mem6 [6];
  logic [7:0] mat6 [6];

  int vectors = 0;
  int errors = 0;
  int we_cycles = 0;

  always #5 clk = ~clk;

  cam_search_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk),
    .rst_n_i(rst_n),
    .req_valid_i(req_valid8),
    .req_ready_o(rdy8),
    .req_op_i(req_op),
    .req_key_i(req_key),
    .req_index_i(req_index),
    .rsp_valid_o(rv8),
    .rsp_ready_i(rsp_ready),
    .rsp_hit_o(hit8),
    .rsp_index_o(ix8),
    .rsp_multi_o(mu8),
    .cell_data_o(data8),
    .cell_write_enable_o(we8),
    .cell_compare_enable_o(ce8),
    .cell_compare_o(cmp8),
    .cell_match_i(match8)
  );

  cam_search_ctrl #(.WIDTH(8), .DEPTH(6)) dut6 (
    .clk(clk),
    .rst_n_i(rst_n),
    .req_valid_i(req_valid6),
    .req_ready_o(rdy6),
    .req_op_i(req_op),
    .req_key_i(req_key),
    .req_index_i(req_index),
    .rsp_valid_o(rv6),
    .rsp_ready_i(rsp_ready),
    .rsp_hit_o(hit6),
    .rsp_index_o(ix6),
    .rsp_multi_o(mu6),
    .cell_data_o(data6),
    .cell_write_enable_o(we6),
    .cell_compare_enable_o(ce6),
    .cell_compare_o(cmp6),
    .cell_match_i(match6)
  );

  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (we8[i]) mem8[i] <= data8;
      if (ce8) mat8[i] <= ~(mem8[i] ^ cmp8);
    end
    for (int i = 0; i < 6; i++) begin
      if (we6[i]) mem6[i] <= data6;
      if (ce6) mat6[i] <= ~(mem6[i] ^ cmp6);
    end
    if (|we8) we_cycles <= we_cycles + 1;
  end

  always_comb begin
    match8 = '0;
    match6 = '0;
    for (int i = 0; i < 8; i++) match8[i*8 +: 8] = mat8[i];
    for (int i = 0; i < 6; i++) match6[i*8 +: 8] = mat6[i];
  end

  task automatic wait_ready(input bit s6);
    int n;
    n = 0;
    while (!(s6 ? rdy6 : rdy8) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      vectors++;
      errors++;
      $display("FAIL ready_timeout got=0 want=1");
    end
  endtask

  task automatic do_cmd(input bit s6, input logic [1:0] op,
                        input logic [2:0] idx, input logic [7:0] key);
    @(negedge clk);
    wait_ready(s6);
    req_op = op;
    req_key = key;
    req_index = idx;
    if (s6) req_valid6 = 1'b1;
    else req_valid8 = 1'b1;
    @(posedge clk);
    #1;
    req_valid6 = 1'b0;
    req_valid8 = 1'b0;
  endtask

  task automatic do_write(input bit s6, input logic [2:0] idx,
                          input logic [7:0] key,
                          output logic [7:0] we);
    do_cmd(s6, 2'b01, idx, key);
    @(negedge clk);
    we = s6 ? {2'b00, we6} : we8;
  endtask

  task automatic do_search(input bit s6, input logic [7:0] key,
                           output logic hit,
                           output logic [2:0] idx,
                           output logic multi,
                           output int lat);
    do_cmd(s6, 2'b00, 3'd0, key);
    lat = 0;
    @(negedge clk);
    while (!(s6 ? rv6 : rv8) && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    hit = s6 ? hit6 : hit8;
    idx = s6 ? ix6 : ix8;
    multi = s6 ? mu6 : mu8;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid8 = 1'b0;
    req_valid6 = 1'b0;
    rsp_ready = 1'b0;
    req_op = 2'b00;
    req_key = 8'h00;
    req_index = 3'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({rv8, hit8, ix8, mu8} !== 6'b0) begin
      errors++;
      $display("FAIL reset_rsp got=%b want=0", {rv8, hit8, ix8, mu8});
    end
    vectors++;
    if ({we8, ce8, data8, cmp8} !== 25'b0) begin
      errors++;
      $display("FAIL reset_cell got=%h want=0",
               {we8, ce8, data8, cmp8});
    end
    vectors++;
    if (rdy8 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b want=1", rdy8);
    end
  endtask

  task automatic test_empty_search;
    logic h, m;
    logic [2:0] ix;
    int lat, w0;
    w0 = we_cycles;
    do_search(1'b0, 8'h00, h, ix, m, lat);
    vectors++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL empty_latency got=%0d want=1", lat);
    end
    vectors++;
    if ({h, ix, m} !== 5'b0) begin
      errors++;
      $display("FAIL empty_rsp got=%b want=00000", {h, ix, m});
    end
    vectors++;
    if (we_cycles !== w0) begin
      errors++;
      $display("FAIL empty_we got=%0d want=%0d", we_cycles, w0);
    end
  endtask

  task automatic test_write_search;
    logic h, m;
    logic [2:0] ix;
    logic [7:0] we;
    int lat;
    do_write(1'b0, 3'd3, 8'hA5, we);
    vectors++;
    if (we !== 8'h08) begin
      errors++;
      $display("FAIL write3_we got=%h want=08", we);
    end
    vectors++;
    if (data8 !== 8'hA5) begin
      errors++;
      $display("FAIL write3_data got=%h want=a5", data8);
    end
    do_search(1'b0, 8'hA5, h, ix, m, lat);
    vectors++;
    if ({h, ix, m} !== {1'b1, 3'd3, 1'b0}) begin
      errors++;
      $display("FAIL srch_a5 got=%b want=10110", {h, ix, m});
    end
    do_search(1'b0, 8'h5A, h, ix, m, lat);
    vectors++;
    if ({h, ix, m} !== 5'b0) begin
      errors++;
      $display("FAIL srch_5a got=%b want=00000", {h, ix, m});
    end
  endtask

  task automatic test_multi;
    logic h, m;
    logic [2:0] ix;
    logic [7:0] we;
    int lat;
    do_write(1'b0, 3'd2, 8'h3C, we);
    do_write(1'b0, 3'd6, 8'h3C, we);
    do_search(1'b0, 8'h3C, h, ix, m, lat);
    vectors++;
    if ({h, ix, m} !== {1'b1, 3'd2, 1'b1}) begin
      errors++;
      $display("FAIL multi_dup got=%b want=10101", {h, ix, m});
    end
    do_cmd(1'b0, 2'b10, 3'd2, 8'h00);
    do_search(1'b0, 8'h3C, h, ix, m, lat);
    vectors++;
    if ({h, ix, m} !== {1'b1, 3'd6, 1'b0}) begin
      errors++;
      $display("FAIL multi_inv got=%b want=11100", {h, ix, m});
    end
    do_cmd(1'b0, 2'b11, 3'd0, 8'h00);
    do_search(1'b0, 8'h3C, h, ix, m, lat);
    vectors++;
    if ({h, ix, m} !== 5'b0) begin
      errors++;
      $display("FAIL multi_flush got=%b want=00000", {h, ix, m});
    end
  endtask

  task automatic test_hold;
    logic [7:0] we;
    do_write(1'b0, 3'd4, 8'h3C, we);
    do_cmd(1'b0, 2'b00, 3'd0, 8'h3C);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if ({rv8, hit8, ix8, mu8, rdy8} !== 7'b1110000) begin
        errors++;
        $display("FAIL hold_%0d got=%b want=1110000", k,
                 {rv8, hit8, ix8, mu8, rdy8});
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if ({rv8, rdy8} !== 2'b01) begin
      errors++;
      $display("FAIL hold_release got=%b want=01", {rv8, rdy8});
    end
  endtask

  task automatic test_overwrite;
    logic h, m;
    logic [2:0] ix;
    logic [7:0] we;
    int lat;
    do_write(1'b0, 3'd3, 8'hA5, we);
    do_write(1'b0, 3'd3, 8'hFF, we);
    do_search(1'b0, 8'hA5, h, ix, m, lat);
    vectors++;
    if ({h, ix, m} !== 5'b0) begin
      errors++;
      $display("FAIL ovw_old got=%b want=00000", {h, ix, m});
    end
    do_search(1'b0, 8'hFF, h, ix, m, lat);
    vectors++;
    if ({h, ix, m} !== {1'b1, 3'd3, 1'b0}) begin
      errors++;
      $display("FAIL ovw_new got=%b want=10110", {h, ix, m});
    end
  endtask

  task automatic test_back_to_back;
    logic h, m;
    logic [2:0] ix;
    logic [7:0] we;
    int lat;
    do_write(1'b0, 3'd0, 8'h12, we);
    do_search(1'b0, 8'h12, h, ix, m, lat);
    vectors++;
    if ({h, ix, m} !== {1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL b2b got=%b want=10000", {h, ix, m});
    end
  endtask

  task automatic test_depth6;
    logic h, m;
    logic [2:0] ix;
    logic [7:0] we;
    int lat;
    do_write(1'b1, 3'd7, 8'h11, we);
    vectors++;
    if (we !== 8'h00) begin
      errors++;
      $display("FAIL d6_oob_we got=%h want=00", we);
    end
    do_search(1'b1, 8'h11, h, ix, m, lat);
    vectors++;
    if ({h, ix, m} !== 5'b0) begin
      errors++;
      $display("FAIL d6_oob_srch got=%b want=00000", {h, ix, m});
    end
    do_write(1'b1, 3'd5, 8'h11, we);
    vectors++;
    if (we !== 8'h20) begin
      errors++;
      $display("FAIL d6_we5 got=%h want=20", we);
    end
    do_search(1'b1, 8'h11, h, ix, m, lat);
    vectors++;
    if ({h, ix, m} !== {1'b1, 3'd5, 1'b0}) begin
      errors++;
      $display("FAIL d6_srch5 got=%b want=11010", {h, ix, m});
    end
  endtask

  task automatic test_reset_mid;
    logic h, m;
    logic [2:0] ix;
    logic [7:0] we;
    int lat;
    do_write(1'b0, 3'd1, 8'h77, we);
    do_cmd(1'b0, 2'b00, 3'd0, 8'h77);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({rv8, ce8, rdy8} !== 3'b001) begin
      errors++;
      $display("FAIL rstmid_imm got=%b want=001", {rv8, ce8, rdy8});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({rv8, rdy8} !== 2'b01) begin
      errors++;
      $display("FAIL rstmid_idle got=%b want=01", {rv8, rdy8});
    end
    do_search(1'b0, 8'h77, h, ix, m, lat);
    vectors++;
    if ({h, ix, m} !== 5'b0) begin
      errors++;
      $display("FAIL rstmid_srch got=%b want=00000", {h, ix, m});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=done");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_empty_search();
    test_write_search();
    test_multi();
    test_hold();
    test_overwrite();
    test_back_to_back();
    test_depth6();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
